// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter in front of the single-port data memory, with bounded m1 lock bursts.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority (m0 wins ties).
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_valid_i,
   output logic          m0_ready_o,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_rvalid_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_valid_i,
   output logic          m1_ready_o,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   input  logic          m1_lock_i,
   output logic          m1_rvalid_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_a_o,
   output logic [DW-1:0] mem_wd_o,
   input  logic [DW-1:0] mem_rd_i
);

   localparam int BW = $clog2(LOCK_MAX + 1);
   localparam logic [BW-1:0] BEATS_MAX = BW'(LOCK_MAX);

   logic          locked_q, locked_d;
   logic [BW-1:0] beats_q, beats_d;
   logic          m0_rvalid_q, m0_rvalid_d;
   logic          m1_rvalid_q, m1_rvalid_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;
   logic          gnt0, gnt1, force_rel;
`ifdef DMEM_ARB_RR_EN
   logic          rr_last_q, rr_last_d;
`endif

   // A grant is only ever given to a valid requester, so grant == accept.
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      force_rel = 1'b0;
      if (locked_q && (beats_q == BEATS_MAX)) begin
         force_rel = 1'b1;
         if (m0_valid_i)      gnt0 = 1'b1;
         else if (m1_valid_i) gnt1 = 1'b1;
      end else if (locked_q && m1_valid_i) begin
         gnt1 = 1'b1;
      end else begin
`ifdef DMEM_ARB_RR_EN
         if (m0_valid_i && m1_valid_i) begin
            gnt0 = rr_last_q;
            gnt1 = ~rr_last_q;
         end else begin
            gnt0 = m0_valid_i;
            gnt1 = m1_valid_i;
         end
`else
         gnt0 = m0_valid_i;
         gnt1 = m1_valid_i & ~m0_valid_i;
`endif
      end
      if (rst_i) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   always_comb begin
      locked_d = locked_q;
      beats_d  = beats_q;
      if (force_rel) begin
         locked_d = 1'b0;
         beats_d  = '0;
      end else if (gnt1) begin
         if (m1_lock_i) begin
            locked_d = 1'b1;
            if (beats_q != BEATS_MAX) beats_d = beats_q + 1'b1;
         end else begin
            locked_d = 1'b0;
            beats_d  = '0;
         end
      end else if (locked_q && !m1_valid_i) begin
         locked_d = 1'b0;
         beats_d  = '0;
      end
   end

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      rr_last_d = rr_last_q;
      if (gnt0)      rr_last_d = 1'b0;
      else if (gnt1) rr_last_d = 1'b1;
   end
`endif

   always_comb begin
      m0_rvalid_d = gnt0 & ~m0_we_i;
      m1_rvalid_d = gnt1 & ~m1_we_i;
      m0_rdata_d  = m0_rvalid_d ? mem_rd_i : m0_rdata_q;
      m1_rdata_d  = m1_rvalid_d ? mem_rd_i : m1_rdata_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         locked_q    <= 1'b0;
         beats_q     <= '0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         locked_q    <= locked_d;
         beats_q     <= beats_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Reset to m1 so m0 wins the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rr_last_q <= 1'b1;
      else       rr_last_q <= rr_last_d;
   end
`endif

   assign m0_ready_o  = gnt0;
   assign m1_ready_o  = gnt1;
   assign mem_we_o    = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
   assign mem_a_o     = gnt1 ? m1_addr_i  : m0_addr_i;
   assign mem_wd_o    = gnt1 ? m1_wdata_i : m0_wdata_i;
   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port `Data_Memory` between the pipeline MEM stage (port m0) and a debug/DMA master (port m1). Each port uses a valid/ready handshake. The arbiter grants at most one access per cycle and drives the memory's `WE`/`A`/`WD` inputs. It returns registered read data on the port that issued the read. Port m1 can lock the memory for short bursts, bounded by a beat counter so m0 cannot starve.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `LOCK_MAX`, 8, maximum consecutive locked m1 beats before a forced release (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `m0_valid` / `m1_valid`  in  1  request present
- `m0_ready` / `m1_ready`  out  1  request accepted this cycle (combinational)
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read
- `m0_addr` / `m1_addr`  in  AW  byte address, passed through unchanged
- `m0_wdata` / `m1_wdata`  in  DW  write data
- `m1_lock`  in  1  keep grant on m1 for the next beat
- `m0_rvalid` / `m1_rvalid`  out  1  read response pulse
- `m0_rdata` / `m1_rdata`  out  DW  read data, held until the next read on that port
- `mem_we`  out  1  to `Data_Memory.WE`
- `mem_a`  out  AW  to `Data_Memory.A`
- `mem_wd`  out  DW  to `Data_Memory.WD`
- `mem_rd`  in  DW  from `Data_Memory.RD` (combinational read)

## Operation
- **Grant.** Grant is computed combinationally each cycle, giving `gnt0` or `gnt1` or neither (never both).
  - `mX_ready = gnt X`.
  - Accept = `valid & ready`.
  - `mX_ready` may depend on `mX_valid`. Masters must not make `valid` depend on `ready`.
- **Lock state.** Registers are `locked` (1 bit), `beats` (`$clog2(LOCK_MAX+1)` bits) and `rr_last` (last granted port).
- **Priority, highest first:**
  1. `locked & m1_valid & beats < LOCK_MAX` → gnt1.
  2. `locked & beats == LOCK_MAX`. This is the forced-release cycle: gnt0 if `m0_valid`, else gnt1 if `m1_valid`. Clear `locked` and `beats` at the end of the cycle.
  3. Normal arbitration (see Configuration).
- **Lock update on an m1 accept.**
  - If `m1_lock == 1`: set `locked` and increment `beats` (saturating at `LOCK_MAX`).
  - If `m1_lock == 0`: clear `locked` and `beats`.
- **Lock drop.** `locked` with `m1_valid == 0` clears `locked` and `beats` at that edge. Normal arbitration applies the same cycle.
- **Memory drive.**
  - `mem_a`/`mem_wd` = granted port's `addr`/`wdata`.
  - `mem_we = accepted & granted_we`, 0 when idle.
  - When idle, `mem_a`/`mem_wd` = m0 fields (don't-care, but stable).
- **Read capture.** For an accepted read on port X, `mX_rdata <= mem_rd` and `mX_rvalid <= 1` at the clock edge. `mX_rvalid` is 0 in every other cycle. Writes produce no response.
- **Reset values.** All `rvalid` 0, all `rdata` 0, `locked` 0, `beats` 0, `rr_last` = m1 (so m0 wins the first tie).

## Timing
- **Accept cycle N.** The memory address is valid in cycle N. A write commits at the rising edge ending N.
- **Read latency.** `mX_rvalid` and `mX_rdata` are valid in cycle N+1. Back-to-back reads on one port give `rvalid` high for consecutive cycles.
- **Throughput.** One access per cycle total. Zero bubbles on grant switch.
- **Read-after-write.** A write in N followed by a read to the same address in N+1 returns the new data in N+2.
- **Reset mid-operation.** Asserting `rst` clears `rvalid`, `rdata` and the lock immediately (asynchronously). An access accepted in the cycle `rst` rises is dropped; ready and `mem_we` are forced to 0 while `rst` is high.

## Configuration
- `DMEM_ARB_RR_EN` defined: normal arbitration is round-robin.
  - On a tie, grant the port ≠ `rr_last`.
  - A single requester always wins.
  - `rr_last` updates on every accept.
- `DMEM_ARB_RR_EN` undefined: fixed priority, m0 always wins ties. `rr_last` is not implemented.
- Lock and forced release behave identically in both builds.

## Test plan
- **Write then read (m0).** m0 writes `32'hAAAAAAAA` to addr 4, then reads addr 4 → `m0_ready` = 1 both cycles, `mem_we` = 1 only in the write cycle, `m0_rvalid` = 1 with `m0_rdata` = `32'hAAAAAAAA` two cycles after the write.
- **Tie arbitration.** Both ports hold `valid` for 4 cycles, reads to addrs 8 and 12 → RR build: grants m0, m1, m0, m1. Fixed build: m0 four times, `m1_ready` = 0 throughout.
- **Lock bound.** With `LOCK_MAX` = 8, m1 does 12 locked reads while m0 continuously requests → m1 gets exactly 8 consecutive grants, then m0 gets one grant, then m1 resumes.
- **Lock drop.** m1 locks for 2 beats, then deasserts `m1_valid` while m0 is valid → m0 is granted in that same cycle, and `locked` reads 0 afterwards.
- **Cross-port RAW.** m1 writes `32'hBBBBBBBB` to addr 16 in cycle N, m0 reads addr 16 in N+1 → `m0_rdata` = `32'hBBBBBBBB` in N+2, and `m1_rvalid` never asserts.
- **Asynchronous reset.** Pulse `rst` mid-cycle while an m0 read is accepted → `m0_rvalid` and `m0_rdata` go to 0 without waiting for a clock edge, no response follows, and the first post-reset tie goes to m0.
